dmem_responder: RTL and testbench

Memory-side responder for the CPU's MEM-stage data port. It replaces the zero-latency data memory with a multi-cycle, word-addressed store that uses a req/ack handshake. It drives a stall signal that freezes the pipeline while an access is outstanding. It sits between the EX/MEM register outputs (address, store data, memwrite/memread) and the MEM/WB register input (read data).

---
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data store behind a req/ack
// handshake, with a combinational stall for the CPU's MEM stage.
`default_nettype none

module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0]     LIMIT    = 32'(DEPTH * 4);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic           lat_we;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic           err_pend;
    logic           bad;
    logic           done;
    logic [31:0]    mem [DEPTH];

    assign bad  = (addr_i[1:0] != 2'b00) || (addr_i >= LIMIT);
    assign done = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_i) state_nx = bad ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            err_pend  <= 1'b0;
            rdata_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i && bad) begin
                        err_pend <= 1'b1;
                        rdata_o  <= '0;
                    end else if (req_i) begin
                        lat_we    <= we_i;
                        lat_idx   <= addr_i[AW+1:2];
                        lat_wdata <= wdata_i;
                        cnt       <= CNT_INIT;
                        err_pend  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!lat_we) begin
                        rdata_o <= mem[lat_idx];
                    end
                end
                RESP: err_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    // Storage is not reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    assign ack_o   = (state == RESP);
    assign err_o   = (state == RESP) && err_pend;
    assign stall_o = ((state == IDLE) && req_i) || (state == WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 and LATENCY=1 instances share stimulus.
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        ack4, err4, stall4, ack1, err1, stall1;
    logic [31:0] rdata4, rdata1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(32), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack4), .rdata_o(rdata4), .err_o(err4), .stall_o(stall4)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cyc;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    endfunction

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One access; cycle 0 is the first cycle req is high. Drops req at drop_cyc.
    task automatic access(input bit sel, input bit we_v, input logic [31:0] a,
                          input logic [31:0] d, input int drop_cyc,
                          output int ack_cyc, output logic err_v,
                          output logic [31:0] rd, output logic [31:0] smask);
        @(posedge clk); #1;
        req = 1'b1; we = we_v; addr = a; wdata = d;
        ack_cyc = -1; err_v = 1'b0; rd = '0; smask = '0;
        for (int c = 0; c < 16; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
                if (c == drop_cyc) begin
                    req = 1'b0; addr = 32'h3; wdata = 32'hFFFF_FFFF;
                end
            end
            @(negedge clk);
            smask[c] = sel ? stall1 : stall4;
            if (sel ? ack1 : ack4) begin
                ack_cyc = c;
                err_v   = sel ? err1 : err4;
                rd      = sel ? rdata1 : rdata4;
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    vec_t        vecs[13];
    int          cyc;
    logic        e;
    logic [31:0] r, sm;
    int          nack, first_ack, second_ack;
    logic [31:0] second_rd;

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 5, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,         5, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h13, 32'h0,         1, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h04, 32'h1234_5678, 5, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,         5, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h80, 32'hCAFE_F00D, 1, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h7C, 32'hA5A5_A5A5, 5, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h7C, 32'h0,         5, 1'b0, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 32'h10, 32'h0BAD_F00D, 5, 1'b0, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b0, 32'h10, 32'h0,         5, 1'b0, 32'h0BAD_F00D};
        vecs[10] = '{1'b0, 32'h04, 32'h0,         5, 1'b0, 32'h1234_5678};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h1,  1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h02, 32'h0,         1, 1'b1, 32'h0};

        // Reset, then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctl", {26'd0, ack4, err4, stall4, ack1, err1, stall1}, 32'h0);
            check("idle_rdata", rdata4 | rdata1, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, -1, cyc, e, r, sm);
            check($sformatf("v%0d_ack_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), r, vecs[i].exp_rdata);
            check($sformatf("v%0d_stall", i), sm, (32'd1 << vecs[i].exp_cyc) - 32'd1);
        end

        // Fill all words, then bad stores must leave every word untouched
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), pat(i), -1, cyc, e, r, sm);
            check("fill_ack", 32'(cyc), 32'd5);
        end
        access(1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF, -1, cyc, e, r, sm);
        check("bad80_err", {31'd0, e}, 32'd1);
        check("bad80_cyc", 32'(cyc), 32'd1);
        access(1'b0, 1'b1, 32'h0A, 32'hFFFF_FFFF, -1, cyc, e, r, sm);
        check("bad0a_err", {31'd0, e}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 1'b0, 32'(i * 4), 32'h0, -1, cyc, e, r, sm);
            check($sformatf("readback_%0d", i), r, pat(i));
        end

        // Held req: one ack per transaction, re-accept in the IDLE cycle after RESP
        nack = 0; first_ack = -1; second_ack = -1; second_rd = '0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 0; c < 16; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
                if (c == 7) req = 1'b0;
            end
            @(negedge clk);
            if (c == 5) check("held_stall_resp", {31'd0, stall4}, 32'd0);
            if (c == 6) check("held_stall_reaccept", {31'd0, stall4}, 32'd1);
            if (ack4) begin
                nack++;
                if (nack == 1) first_ack = c;
                if (nack == 2) begin second_ack = c; second_rd = rdata4; end
            end
        end
        check("held_nack", 32'(nack), 32'd2);
        check("held_ack1", 32'(first_ack), 32'd5);
        check("held_ack2", 32'(second_ack), 32'd11);
        check("held_rdata", second_rd, pat(4));

        // Reset in cycle 2 of a store aborts it
        access(1'b0, 1'b1, 32'h08, 32'h1111_1111, -1, cyc, e, r, sm);
        check("pre_store_ack", 32'(cyc), 32'd5);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'h5A5A_5A5A;
        nack = 0;
        @(negedge clk); nack += int'(ack4);
        @(posedge clk); #1;
        @(negedge clk); nack += int'(ack4);
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        @(negedge clk); nack += int'(ack4);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_state_idle", {31'd0, stall4}, 32'd0);
        check("rst_rdata", rdata4, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); nack += int'(ack4);
        end
        check("rst_no_ack", 32'(nack), 32'd0);
        access(1'b0, 1'b0, 32'h08, 32'h0, -1, cyc, e, r, sm);
        check("rst_load_old", r, 32'h1111_1111);

        // LATENCY=1 instance
        pulse_reset();
        access(1'b1, 1'b1, 32'h0C, 32'h600D_CAFE, -1, cyc, e, r, sm);
        check("l1_store_cyc", 32'(cyc), 32'd2);
        check("l1_store_stall", sm, 32'h3);
        access(1'b1, 1'b0, 32'h0C, 32'h0, -1, cyc, e, r, sm);
        check("l1_load_cyc", 32'(cyc), 32'd2);
        check("l1_load_rdata", r, 32'h600D_CAFE);
        access(1'b1, 1'b0, 32'h0C, 32'h0, 1, cyc, e, r, sm);
        check("l1_drop_cyc", 32'(cyc), 32'd2);
        check("l1_drop_rdata", r, 32'h600D_CAFE);
        check("l1_drop_err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b0, 32'h81, 32'h0, -1, cyc, e, r, sm);
        check("l1_bad_cyc", 32'(cyc), 32'd1);
        check("l1_bad_err", {31'd0, e}, 32'd1);
        check("l1_bad_rdata", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
